// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants and helpers for the elastic pipeline buffer.
package pipe_stage_buf_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Width of the occupancy counter needed to represent 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : pipe_stage_buf_pkg

// File: rtl/pipe_stage_buf_stage.sv
// One valid+data register stage. The flush input discards the held entry
// (valid clears, data is kept); load captures d_in and marks the stage valid.
module pipe_stage
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_out,
    output logic [WIDTH-1:0] d_out
);

    logic             v_r;
    logic [WIDTH-1:0] d_r;

    // Stage state: reset clears all, discard clears only valid, load captures.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v_r <= 1'b0;
            d_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            v_r <= 1'b0;
            d_r <= d_r;
        end else if (load) begin
            v_r <= 1'b1;
            d_r <= d_in;
        end else begin
            v_r <= v_r;
            d_r <= d_r;
        end
    end

    assign v_out = v_r;
    assign d_out = d_r;

endmodule : pipe_stage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline buffer of DEPTH stages with bubble collapsing, flush and
// a registered occupancy count.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] v_s;
    logic [WIDTH-1:0] d_s   [DEPTH];
    logic [WIDTH-1:0] din_s [DEPTH];
    logic [DEPTH:0]   r_s;
    logic [DEPTH-1:0] load_s;
    logic [DEPTH-1:0] clr_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [CW-1:0]    count_r;

    // Ready into each stage: free, or every stage downstream of it is full
    // and the consumer takes the head (unrolled form of !v[i] || r[i+1]).
    always_comb begin
        logic tail_full_s;
        tail_full_s = 1'b1;
        r_s         = {(DEPTH+1){1'b0}};
        r_s[DEPTH]  = out_ready;
        for (int i = 0; i < DEPTH; i++) begin
            tail_full_s = 1'b1;
            for (int j = i; j < DEPTH; j++) begin
                tail_full_s = tail_full_s & v_s[j];
            end
            r_s[i] = out_ready | ~tail_full_s;
        end
    end

    assign in_ready   = rst & r_s[0] & ~flush;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = v_s[DEPTH-1] & out_ready & ~flush;

    // Per-stage load enables, load data and discard requests. A stage whose
    // entry moves on without a replacement arriving is discarded as well.
    always_comb begin
        load_s = {DEPTH{1'b0}};
        clr_s  = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            din_s[i] = {WIDTH{1'b0}};
        end
        din_s[0]  = in_data;
        load_s[0] = in_fire_s;
        for (int i = 1; i < DEPTH; i++) begin
            load_s[i] = v_s[i-1] & r_s[i] & ~flush;
            din_s[i]  = d_s[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            clr_s[i] = flush | (v_s[i] & r_s[i+1] & ~load_s[i]);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (clr_s[g]),
            .load  (load_s[g]),
            .d_in  (din_s[g]),
            .v_out (v_s[g]),
            .d_out (d_s[g])
        );
    end

    // Occupancy: +1 per accept, -1 per consumed head, zero on flush or reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(in_fire_s) - CW'(out_fire_s);
        end
    end

    assign out_valid = v_s[DEPTH-1];
    assign out_data  = d_s[DEPTH-1];
    assign count     = count_r;

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: five instances (DEPTH 1..5, WIDTH 8), an
// entry-list model checked every cycle, plus hand-computed directed checks.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:1] rst_v, flush_v, in_valid_v, out_ready_v, in_ready_v, out_valid_v;
    logic [7:0] in_data_a  [1:5];
    logic [7:0] out_data_a [1:5];
    logic [2:0] count_a    [1:5];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar k = 1; k <= 5; k++) begin : g_dut
        localparam int CWK = $clog2(k + 1);
        logic [CWK-1:0] cnt;
        pipe_stage_buf #(.WIDTH(8), .DEPTH(k)) u_dut (
            .clk       (clk),
            .rst       (rst_v[k]),
            .flush     (flush_v[k]),
            .in_valid  (in_valid_v[k]),
            .in_data   (in_data_a[k]),
            .in_ready  (in_ready_v[k]),
            .out_valid (out_valid_v[k]),
            .out_data  (out_data_a[k]),
            .out_ready (out_ready_v[k]),
            .count     (cnt)
        );
        assign count_a[k] = 3'(cnt);
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [DEPTH=%0d] t=%0t: got %0h want %0h", nm, k, $time, act, exp);
        end
    endtask

    // Model: per instance, a list of entries (oldest first) with the stage
    // position each one occupies, and the last payload to reach the tail.
    int         ent_pos [1:5][16];
    logic [7:0] ent_dat [1:5][16];
    int         ent_n   [1:5];
    logic [7:0] last_d  [1:5];
    logic       mv [16];
    logic       exp_rdy, exp_ov;
    int         w, np;

    always @(negedge clk) begin
        for (int k = 1; k <= 5; k++) begin
            // An entry advances if the slot ahead is empty or its occupant advances;
            // the head in the last stage leaves when the consumer is ready.
            for (int e = 0; e < ent_n[k]; e++) begin
                if (ent_pos[k][e] == k - 1)
                    mv[e] = out_ready_v[k];
                else if (e > 0 && ent_pos[k][e-1] == ent_pos[k][e] + 1)
                    mv[e] = mv[e-1];
                else
                    mv[e] = 1'b1;
            end
            exp_rdy = rst_v[k] && !flush_v[k] &&
                      (ent_n[k] == 0 || ent_pos[k][ent_n[k]-1] != 0 || mv[ent_n[k]-1]);
            exp_ov  = ent_n[k] > 0 && ent_pos[k][0] == k - 1;
            chk("m_in_ready",  k, 32'(in_ready_v[k]),  32'(exp_rdy));
            chk("m_out_valid", k, 32'(out_valid_v[k]), 32'(exp_ov));
            chk("m_out_data",  k, 32'(out_data_a[k]),  32'(last_d[k]));
            chk("m_count",     k, 32'(count_a[k]),     32'(ent_n[k]));
            if (!rst_v[k]) begin
                ent_n[k]  = 0;
                last_d[k] = 8'h00;
            end else if (flush_v[k]) begin
                ent_n[k] = 0;
            end else begin
                w = 0;
                for (int e = 0; e < ent_n[k]; e++) begin
                    if (!(mv[e] && ent_pos[k][e] == k - 1)) begin
                        np = ent_pos[k][e] + (mv[e] ? 1 : 0);
                        if (mv[e] && np == k - 1) last_d[k] = ent_dat[k][e];
                        ent_dat[k][w] = ent_dat[k][e];
                        ent_pos[k][w] = np;
                        w++;
                    end
                end
                if (in_valid_v[k] && exp_rdy) begin
                    ent_pos[k][w] = 0;
                    ent_dat[k][w] = in_data_a[k];
                    if (k == 1) last_d[k] = in_data_a[k];
                    w++;
                end
                ent_n[k] = w;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 1; k <= 5; k++) begin
            ent_n[k]     = 0;
            last_d[k]    = 8'h00;
            in_data_a[k] = 8'h00;
        end
        rst_v = '0; flush_v = '0; in_valid_v = '0; out_ready_v = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_v = '1;

        // Reset state.
        tick(); #1;
        for (int k = 1; k <= 5; k++) begin
            chk("rst_count", k, 32'(count_a[k]), 0);
            chk("rst_out_valid", k, 32'(out_valid_v[k]), 0);
            chk("rst_out_data", k, 32'(out_data_a[k]), 0);
        end

        // Streaming, DEPTH=2: 0x1..0x8 back to back.
        out_ready_v[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            in_valid_v[2] = (c < 8);
            in_data_a[2]  = 8'(c + 1);
            #1;
            if (c < 8) chk("stream_in_ready", 2, 32'(in_ready_v[2]), 1);
            if (c >= 2) begin
                chk("stream_out_valid", 2, 32'(out_valid_v[2]), 1);
                chk("stream_out_data", 2, 32'(out_data_a[2]), 32'(c - 1));
            end
            if (c >= 2 && c <= 8) chk("stream_count", 2, 32'(count_a[2]), 2);
        end
        tick();

        // Backpressure, DEPTH=2.
        out_ready_v[2] = 1'b0;
        tick(); in_valid_v[2] = 1'b1; in_data_a[2] = 8'h0A; #1;
        chk("bp_acc_a", 2, 32'(in_ready_v[2]), 1);
        tick(); in_data_a[2] = 8'h0B; #1;
        chk("bp_acc_b", 2, 32'(in_ready_v[2]), 1);
        tick(); in_data_a[2] = 8'h0C; #1;
        chk("bp_refuse_c", 2, 32'(in_ready_v[2]), 0);
        chk("bp_full_count", 2, 32'(count_a[2]), 2);
        tick(); out_ready_v[2] = 1'b1; #1;
        chk("bp_full_drain_ready", 2, 32'(in_ready_v[2]), 1);
        chk("bp_out_a", 2, 32'(out_data_a[2]), 32'h0A);
        tick(); in_valid_v[2] = 1'b0; #1;
        chk("bp_out_b", 2, 32'(out_data_a[2]), 32'h0B);
        chk("bp_count_held", 2, 32'(count_a[2]), 2);
        tick(); #1;
        chk("bp_out_c", 2, 32'(out_data_a[2]), 32'h0C);
        chk("bp_count_1", 2, 32'(count_a[2]), 1);
        tick(); #1;
        chk("bp_empty", 2, 32'(out_valid_v[2]), 0);

        // Bubble collapse, DEPTH=4.
        out_ready_v[4] = 1'b0;
        tick(); in_valid_v[4] = 1'b1; in_data_a[4] = 8'h55; #1;
        chk("bub_acc", 4, 32'(in_ready_v[4]), 1);
        tick(); in_valid_v[4] = 1'b0;
        repeat (2) tick();
        tick(); in_valid_v[4] = 1'b1; in_data_a[4] = 8'h66; #1;
        chk("bub_tail_valid", 4, 32'(out_valid_v[4]), 1);
        chk("bub_count_1", 4, 32'(count_a[4]), 1);
        chk("bub_tail_data", 4, 32'(out_data_a[4]), 32'h55);
        chk("bub_ready", 4, 32'(in_ready_v[4]), 1);
        tick(); in_valid_v[4] = 1'b0;
        repeat (2) tick();
        tick(); out_ready_v[4] = 1'b1; #1;
        chk("bub_count_2", 4, 32'(count_a[4]), 2);
        chk("bub_hold_55", 4, 32'(out_data_a[4]), 32'h55);
        tick(); #1;
        chk("bub_66_next", 4, 32'(out_data_a[4]), 32'h66);
        chk("bub_66_valid", 4, 32'(out_valid_v[4]), 1);
        tick(); #1;
        chk("bub_drained", 4, 32'(count_a[4]), 0);

        // Flush, DEPTH=3.
        out_ready_v[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(); in_valid_v[3] = 1'b1; in_data_a[3] = 8'(c + 1); #1;
            chk("fl_fill_ready", 3, 32'(in_ready_v[3]), 1);
        end
        tick();
        in_data_a[3] = 8'h77; out_ready_v[3] = 1'b1; flush_v[3] = 1'b1; #1;
        chk("fl_full_count", 3, 32'(count_a[3]), 3);
        chk("fl_refuse", 3, 32'(in_ready_v[3]), 0);
        tick(); flush_v[3] = 1'b0; in_valid_v[3] = 1'b0; out_ready_v[3] = 1'b0; #1;
        chk("fl_count", 3, 32'(count_a[3]), 0);
        chk("fl_out_valid", 3, 32'(out_valid_v[3]), 0);
        chk("fl_data_kept", 3, 32'(out_data_a[3]), 32'h01);
        tick(); #1;
        chk("fl_no_77", 3, 32'(out_valid_v[3]), 0);

        // Reset mid-stream, DEPTH=2.
        out_ready_v[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(); in_valid_v[2] = 1'b1; in_data_a[2] = 8'(16 + c);
        end
        tick(); #1;
        chk("rs_count_2", 2, 32'(count_a[2]), 2);
        rst_v[2] = 1'b0; in_data_a[2] = 8'h13; #1;
        chk("rs_ready_low", 2, 32'(in_ready_v[2]), 0);
        tick(); #1;
        chk("rs_count_0", 2, 32'(count_a[2]), 0);
        chk("rs_data_0", 2, 32'(out_data_a[2]), 0);
        chk("rs_valid_0", 2, 32'(out_valid_v[2]), 0);
        chk("rs_ready_held", 2, 32'(in_ready_v[2]), 0);
        tick(); rst_v[2] = 1'b1; in_data_a[2] = 8'h99; #1;
        chk("rs_ready_back", 2, 32'(in_ready_v[2]), 1);
        tick(); in_valid_v[2] = 1'b0; #1;
        chk("rs_lat_1", 2, 32'(out_valid_v[2]), 0);
        tick(); #1;
        chk("rs_lat_2", 2, 32'(out_valid_v[2]), 1);
        chk("rs_lat_data", 2, 32'(out_data_a[2]), 32'h99);
        tick();

        // Random traffic on DEPTH=1 and DEPTH=5 against the model.
        for (int c = 0; c < 10000; c++) begin
            tick();
            in_valid_v[1]  = 1'($urandom_range(0, 1));
            out_ready_v[1] = 1'($urandom_range(0, 1));
            in_data_a[1]   = 8'($urandom_range(0, 255));
            in_valid_v[5]  = 1'($urandom_range(0, 1));
            out_ready_v[5] = 1'($urandom_range(0, 1));
            in_data_a[5]   = 8'($urandom_range(0, 255));
        end
        tick();
        in_valid_v = '0; out_ready_v = '1;
        repeat (8) tick();
        #1;
        chk("rnd_d1_drained", 1, 32'(count_a[1]), 0);
        chk("rnd_d5_drained", 5, 32'(count_a[5]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipe_stage_buf
